// File: rtl/flags_shadow_stack_if.sv
// Flag-control and shadow-stack status bundle between the control unit and flags_shadow_stack.
interface flags_shadow_stack_if #(
  parameter int unsigned N_FLAGS = 2,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [N_FLAGS-1:0] FLG_CLR;
  logic [N_FLAGS-1:0] FLG_SET;
  logic [N_FLAGS-1:0] FLG_LD;
  logic [N_FLAGS-1:0] FLG_IN;
  logic               FLG_PUSH;
  logic               FLG_POP;
  logic               ERR_CLR;
  logic [N_FLAGS-1:0] FLAGS;
  logic [CNT_W-1:0]   STK_CNT;
  logic               STK_EMPTY;
  logic               STK_FULL;
  logic               STK_OVF;
  logic               STK_UNF;

  modport master (
    output FLG_CLR, FLG_SET, FLG_LD, FLG_IN, FLG_PUSH, FLG_POP, ERR_CLR,
    input  FLAGS, STK_CNT, STK_EMPTY, STK_FULL, STK_OVF, STK_UNF
  );

  modport slave (
    input  FLG_CLR, FLG_SET, FLG_LD, FLG_IN, FLG_PUSH, FLG_POP, ERR_CLR,
    output FLAGS, STK_CNT, STK_EMPTY, STK_FULL, STK_OVF, STK_UNF
  );
endinterface

// File: rtl/flags_shadow_stack.sv
// Status-flag register with a DEPTH-entry LIFO shadow stack for nested interrupt entry/RETI.
module flags_shadow_stack #(
  parameter int unsigned N_FLAGS = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  flags_shadow_stack_if.slave     bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N_FLAGS-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [N_FLAGS-1:0] stk_q [DEPTH];
  logic [N_FLAGS-1:0] stk_d [DEPTH];

  logic               full, empty, restore;
  logic [IDX_W-1:0]   top_idx, wr_idx;
  logic [N_FLAGS-1:0] popped;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_idx  = IDX_W'(cnt_q);
  assign top_idx = IDX_W'(cnt_q - CNT_W'(1));

  // Stack pointer/contents, sticky errors, and per-flag priority update.
  always_comb begin
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q & ~bus.ERR_CLR;
    unf_d   = unf_q & ~bus.ERR_CLR;
    restore = 1'b0;
    popped  = flags_q;

    unique case ({bus.FLG_PUSH, bus.FLG_POP})
      2'b10: begin
        if (!full) begin
          stk_d[wr_idx] = flags_q;
          cnt_d         = cnt_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          restore = 1'b1;
          popped  = stk_q[top_idx];
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      2'b11: begin
        // Exchange: on an empty stack the current word is "popped" back onto itself.
        restore = 1'b1;
        if (!empty) begin
          popped         = stk_q[top_idx];
          stk_d[top_idx] = flags_q;
        end
      end
      default: ;
    endcase

    flags_d = flags_q;
    for (int i = 0; i < int'(N_FLAGS); i++) begin
      if (bus.FLG_CLR[i])      flags_d[i] = 1'b0;
      else if (bus.FLG_SET[i]) flags_d[i] = 1'b1;
      else if (restore)        flags_d[i] = popped[i];
      else if (bus.FLG_LD[i])  flags_d[i] = bus.FLG_IN[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      flags_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) stk_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stk_q   <= stk_d;
    end
  end

  assign bus.FLAGS     = flags_q;
  assign bus.STK_CNT   = cnt_q;
  assign bus.STK_EMPTY = empty;
  assign bus.STK_FULL  = full;
  assign bus.STK_OVF   = ovf_q;
  assign bus.STK_UNF   = unf_q;
endmodule

// File: tb/tb_flags_shadow_stack.sv
// Bench for flags_shadow_stack: directed plan with literal expectations, then random traffic vs a queue model.
module tb_flags_shadow_stack;
  localparam int unsigned NF = 2;
  localparam int unsigned DP = 4;

  logic CLK;
  logic RST_N;

  flags_shadow_stack_if #(.N_FLAGS(NF), .DEPTH(DP)) bus ();

  flags_shadow_stack #(.N_FLAGS(NF), .DEPTH(DP)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: stack as a queue, flags as a plain word.
  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_stk[$];
  logic          m_ovf, m_unf;
  bit            m_ok = 0;

  always @(posedge CLK) begin
    logic [NF-1:0] pre, pv;
    bit            rest, oerr, uerr;
    if (!RST_N) begin
      m_flags = '0;
      m_stk.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_ok    = 1;
    end else if (m_ok) begin
      pre  = m_flags;
      pv   = pre;
      rest = 0; oerr = 0; uerr = 0;
      if (bus.FLG_PUSH && bus.FLG_POP) begin
        rest = 1;
        if (m_stk.size() > 0) begin
          pv = m_stk.pop_back();
          m_stk.push_back(pre);
        end
      end else if (bus.FLG_PUSH) begin
        if (m_stk.size() < int'(DP)) m_stk.push_back(pre);
        else oerr = 1;
      end else if (bus.FLG_POP) begin
        if (m_stk.size() > 0) begin
          pv = m_stk.pop_back();
          rest = 1;
        end else uerr = 1;
      end
      for (int i = 0; i < int'(NF); i++) begin
        if (bus.FLG_CLR[i])      m_flags[i] = 1'b0;
        else if (bus.FLG_SET[i]) m_flags[i] = 1'b1;
        else if (rest)           m_flags[i] = pv[i];
        else if (bus.FLG_LD[i])  m_flags[i] = bus.FLG_IN[i];
      end
      m_ovf = oerr ? 1'b1 : (bus.ERR_CLR ? 1'b0 : m_ovf);
      m_unf = uerr ? 1'b1 : (bus.ERR_CLR ? 1'b0 : m_unf);
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge CLK) begin
    if (m_ok) begin
      chk("flags",     8'(bus.FLAGS),     8'(m_flags));
      chk("stk_cnt",   8'(bus.STK_CNT),   8'(m_stk.size()));
      chk("stk_empty", 8'(bus.STK_EMPTY), 8'(m_stk.size() == 0));
      chk("stk_full",  8'(bus.STK_FULL),  8'(m_stk.size() == int'(DP)));
      chk("stk_ovf",   8'(bus.STK_OVF),   8'(m_ovf));
      chk("stk_unf",   8'(bus.STK_UNF),   8'(m_unf));
    end
  end

  task automatic step(input logic rst_n, input logic [NF-1:0] clr, input logic [NF-1:0] set,
                      input logic [NF-1:0] ld, input logic [NF-1:0] din,
                      input logic push, input logic pop, input logic ec);
    @(negedge CLK);
    RST_N        = rst_n;
    bus.FLG_CLR  = clr;
    bus.FLG_SET  = set;
    bus.FLG_LD   = ld;
    bus.FLG_IN   = din;
    bus.FLG_PUSH = push;
    bus.FLG_POP  = pop;
    bus.ERR_CLR  = ec;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
  endtask

  task automatic load(input logic [NF-1:0] v);
    step(1, 2'b00, 2'b00, 2'b11, v, 0, 0, 0);
  endtask

  task automatic push_ld(input logic [NF-1:0] v);
    step(1, 2'b00, 2'b00, 2'b11, v, 1, 0, 0);
  endtask

  task automatic pop1();
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.FLG_CLR = '0; bus.FLG_SET = '0; bus.FLG_LD = '0; bus.FLG_IN = '0;
    bus.FLG_PUSH = 1'b0; bus.FLG_POP = 1'b0; bus.ERR_CLR = 1'b0;

    // Reset and basic controls
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("rst_flags", 8'(bus.FLAGS), 8'h00);
    chk("rst_cnt",   8'(bus.STK_CNT), 8'h00);
    step(1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    chk("set0", 8'(bus.FLAGS), 8'h01);
    step(1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    chk("clr_wins", 8'(bus.FLAGS[0]), 8'h00);

    // Nesting three deep
    load(2'b01); pop1(); // empty pop raises UNF; cleared below
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    chk("unf_cleared", 8'(bus.STK_UNF), 8'h00);
    load(2'b01); push_ld(2'b10);
    chk("nest_cnt1", 8'(bus.STK_CNT), 8'd1);
    push_ld(2'b11);
    chk("nest_cnt2", 8'(bus.STK_CNT), 8'd2);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    chk("nest_cnt3", 8'(bus.STK_CNT), 8'd3);
    pop1(); chk("nest_pop1", 8'(bus.FLAGS), 8'h03);
    pop1(); chk("nest_pop2", 8'(bus.FLAGS), 8'h02);
    pop1(); chk("nest_pop3", 8'(bus.FLAGS), 8'h01);
    chk("nest_empty", 8'(bus.STK_EMPTY), 8'h01);

    // Overflow: stored 01,10,11,00 then a dropped push
    push_ld(2'b10); push_ld(2'b11); push_ld(2'b00); push_ld(2'b01);
    chk("ovf_full", 8'(bus.STK_FULL), 8'h01);
    chk("ovf_pre",  8'(bus.STK_OVF), 8'h00);
    push_ld(2'b10);
    chk("ovf_cnt",  8'(bus.STK_CNT), 8'd4);
    chk("ovf_set",  8'(bus.STK_OVF), 8'h01);
    chk("ovf_flags", 8'(bus.FLAGS), 8'h02);
    pop1(); chk("lifo0", 8'(bus.FLAGS), 8'h00);
    pop1(); chk("lifo1", 8'(bus.FLAGS), 8'h03);
    pop1(); chk("lifo2", 8'(bus.FLAGS), 8'h02);
    pop1(); chk("lifo3", 8'(bus.FLAGS), 8'h01);
    chk("ovf_sticky", 8'(bus.STK_OVF), 8'h01);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    chk("ovf_clr", 8'(bus.STK_OVF), 8'h00);

    // Underflow and sticky error
    step(1, 2'b00, 2'b00, 2'b11, 2'b10, 0, 1, 0);
    chk("unf_flags", 8'(bus.FLAGS), 8'h02);
    chk("unf_set",   8'(bus.STK_UNF), 8'h01);
    chk("unf_cnt",   8'(bus.STK_CNT), 8'd0);
    idle();
    chk("unf_hold",  8'(bus.STK_UNF), 8'h01);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1);
    chk("unf_err_wins", 8'(bus.STK_UNF), 8'h01);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    chk("unf_clr", 8'(bus.STK_UNF), 8'h00);

    // Exchange, non-empty then empty
    load(2'b01); push_ld(2'b10);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    chk("xchg_flags", 8'(bus.FLAGS), 8'h01);
    chk("xchg_cnt",   8'(bus.STK_CNT), 8'd1);
    pop1();
    chk("xchg_entry", 8'(bus.FLAGS), 8'h02);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    chk("xchg_e_flags", 8'(bus.FLAGS), 8'h02);
    chk("xchg_e_cnt",   8'(bus.STK_CNT), 8'd0);
    chk("xchg_e_err",   8'({bus.STK_OVF, bus.STK_UNF}), 8'h00);

    // Priority during restore
    load(2'b11);
    step(1, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 0);
    step(1, 2'b01, 2'b00, 2'b10, 2'b00, 0, 1, 0);
    chk("prio", 8'(bus.FLAGS), 8'h02);

    // Reset mid-nest discards the stack
    push_ld(2'b01); push_ld(2'b10);
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    chk("midrst_cnt",   8'(bus.STK_CNT), 8'd0);
    chk("midrst_flags", 8'(bus.FLAGS), 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [NF-1:0] c, s, l, d;
      logic pu, po, ec, rn;
      for (int i = 0; i < int'(NF); i++) begin
        c[i] = ($urandom_range(7) == 0);
        s[i] = ($urandom_range(7) == 0);
        l[i] = ($urandom_range(2) == 0);
      end
      d  = NF'($urandom);
      pu = ($urandom_range(2) == 0);
      po = ($urandom_range(2) == 0);
      ec = ($urandom_range(15) == 0);
      rn = ($urandom_range(299) != 0);
      step(rn, c, s, l, d, pu, po, ec);
    end

    idle();
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/flags_shadow_stack.md
# flags_shadow_stack

Parametrised processor status-flag register with a multi-level shadow stack for nested interrupts. It holds N_FLAGS flags, for example C and Z, each with its own clear, set and load controls. On interrupt entry it pushes the whole flag word onto a DEPTH-entry LIFO, and on RETI it restores the word from the LIFO. It sits between the ALU flag outputs and the control unit, and replaces the single-level C/Z shadow scheme so that interrupts can nest up to DEPTH levels.

## Interface
Parameters:
- N_FLAGS, default 2: number of flags. Bit 0 is C and bit 1 is Z; higher bits are generic.
- DEPTH, default 4: number of shadow stack entries, ≥1.

Ports:
- CLK  in  1  clock. All state updates on the rising edge.
- RST_N  in  1  reset. One clock; reset is synchronous and active-low.
- FLG_CLR  in  N_FLAGS  per-flag clear.
- FLG_SET  in  N_FLAGS  per-flag set.
- FLG_LD  in  N_FLAGS  per-flag load from FLG_IN.
- FLG_IN  in  N_FLAGS  new flag values from the ALU.
- FLG_PUSH  in  1  interrupt entry: push the current FLAGS.
- FLG_POP  in  1  RETI: restore FLAGS from the top of the stack.
- ERR_CLR  in  1  clear the sticky STK_OVF and STK_UNF bits.
- FLAGS  out  N_FLAGS  current flag register.
- STK_CNT  out  $clog2(DEPTH+1)  number of occupied entries.
- STK_EMPTY  out  1  STK_CNT==0.
- STK_FULL  out  1  STK_CNT==DEPTH.
- STK_OVF  out  1  sticky: a push was attempted while the stack was full.
- STK_UNF  out  1  sticky: a pop was attempted while the stack was empty.

## Operation
- Reset (RST_N=0 at an edge): FLAGS=0, STK_CNT=0, STK_OVF=0, STK_UNF=0, all stack entries =0. Reset overrides every other input.
- Per-flag next-state priority for bit i: FLG_CLR[i] → 0; else FLG_SET[i] → 1; else a restore (an effective pop) → popped[i]; else FLG_LD[i] → FLG_IN[i]; else hold.
- A push always stores the pre-edge FLAGS value. Same-cycle CLR, SET and LD updates do not affect the stored value.
- Push only, STK_CNT<DEPTH: entry[STK_CNT] ← FLAGS, then STK_CNT+1.
- Push only, STK_FULL: the stack and STK_CNT are unchanged, the push is dropped, and STK_OVF ← 1. FLAGS updates normally.
- Pop only, STK_CNT>0: popped = entry[STK_CNT-1], then STK_CNT-1. The entry content need not be cleared.
- Pop only, STK_EMPTY: no restore happens, STK_CNT stays 0, STK_UNF ← 1. FLAGS follow the CLR, SET and LD path.
- Push and pop together (exchange):
  - STK_CNT>0: popped = entry[STK_CNT-1], that entry ← pre-edge FLAGS, STK_CNT unchanged.
  - STK_EMPTY: popped = pre-edge FLAGS, the stack is untouched, no error is flagged.
  - In both cases the restore takes part in the per-flag priority above.
- ERR_CLR clears both sticky bits. An error detected in the same cycle wins, so the bit ends at 1.
- STK_CNT, STK_EMPTY and STK_FULL are combinational decodes of the registered count. STK_CNT never leaves the range 0..DEPTH.

## Timing
- All outputs are registered state or direct decodes of it. Each change is visible one cycle after the controlling edge.
- Latency:
  - CLR, SET, LD to FLAGS: 1 cycle.
  - Pop to restored FLAGS: 1 cycle.
  - Push to STK_CNT increment: 1 cycle.
- Back-to-back pushes or pops on consecutive cycles are supported with no bubble. A pop on the cycle after a push returns the value just pushed.
- A reset assertion in the middle of a nest discards all stacked state on that edge, with no partial restore.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset and basic controls: assert RST_N=0, release it, then apply FLG_SET=2'b01.
  - Required: FLAGS=00 and STK_CNT=0 after reset, then FLAGS=01.
  - Then apply CLR[0] together with SET[0]. Required: FLAGS[0]=0, because clear wins.
- Nesting: with DEPTH=4, perform three pushes holding FLAGS=01, 10 and 11 in turn, then three pops.
  - Required: STK_CNT goes 1, 2, 3.
  - Required: FLAGS restore in the order 11, 10, 01, then STK_EMPTY=1.
- Overflow: perform 5 pushes with DEPTH=4.
  - Required: STK_FULL=1 after the 4th push, STK_CNT stays 4, STK_OVF=1 after the 5th.
  - Then perform 4 pops. Required: the first four pushed values come back in LIFO order.
- Underflow and sticky error: pop while empty with FLG_LD=11 and FLG_IN=10.
  - Required: FLAGS=10, STK_UNF=1, STK_CNT=0.
  - Required: STK_UNF holds until ERR_CLR, and stays 1 if ERR_CLR coincides with another empty pop.
- Exchange: with STK_CNT=1 holding entry 01 and FLAGS=10, assert push and pop together.
  - Required: FLAGS=01, entry becomes 10, STK_CNT=1.
  - Repeat with the stack empty. Required: FLAGS unchanged and no error.
- Priority during a restore: pop with top=11 while SET=00, CLR=01 and LD=10 with FLG_IN=00.
  - Required: FLAGS=10. Bit 0 is cleared; bit 1 takes the restore over the load.
